// File: rtl/mont_pkg.sv
// Shared types and defaults for the Montgomery word-serial bridge.
package mont_pkg;

   localparam int unsigned MONT_WORD_W    = 32;
   localparam int unsigned MONT_OPERAND_W = 512;

   typedef enum logic [1:0] {
      ST_LOAD   = 2'd0,
      ST_START  = 2'd1,
      ST_WAIT   = 2'd2,
      ST_UNLOAD = 2'd3
   } mont_state_t;

   typedef enum logic [1:0] {
      SEL_A = 2'd0,
      SEL_B = 2'd1,
      SEL_M = 2'd2
   } mont_sel_t;

   // Operand order on the input stream is A, then B, then M, then back to A.
   function automatic mont_sel_t mont_next_sel(input mont_sel_t sel);
      case (sel)
         SEL_A:   return SEL_B;
         SEL_B:   return SEL_M;
         default: return SEL_A;
      endcase
   endfunction

endpackage

// File: rtl/mont_word_packer.sv
// One OPERAND_W register with a word write port, a full-width load port and
// a word read mux. Full-width load has priority over the word write.
module mont_word_packer
   import mont_pkg::*;
#(
   parameter int unsigned WORD_W    = MONT_WORD_W,
   parameter int unsigned OPERAND_W = MONT_OPERAND_W,
   localparam int unsigned NWORDS   = OPERAND_W / WORD_W,
   localparam int unsigned IDX_W    = (NWORDS > 1) ? $clog2(NWORDS) : 1
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 i_we,
   input  logic [IDX_W-1:0]     i_wr_idx,
   input  logic [WORD_W-1:0]    i_wr_data,
   input  logic                 i_ld,
   input  logic [OPERAND_W-1:0] i_ld_data,
   input  logic [IDX_W-1:0]     i_rd_idx,
   output logic [WORD_W-1:0]    o_rd_data,
   output logic [OPERAND_W-1:0] o_value
);

   logic [OPERAND_W-1:0] r_val;

   // Register update: clear on reset, whole load, or single addressed word.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_val <= '0;
      end else if (i_ld) begin
         r_val <= i_ld_data;
      end else if (i_we) begin
         r_val[i_wr_idx*WORD_W +: WORD_W] <= i_wr_data;
      end
   end

   // Word read mux.
   always_comb begin
      o_rd_data = r_val[i_rd_idx*WORD_W +: WORD_W];
   end

   assign o_value = r_val;

endmodule

// File: rtl/mont_word_bridge.sv
// Word-serial front/back end for the 512-bit Montgomery multiplier: packs
// A, B, M from a 32-bit stream, starts the multiplier, waits for done (with a
// timeout) and streams the captured result back out LSW first.
module mont_word_bridge
   import mont_pkg::*;
#(
   parameter int unsigned WORD_W      = MONT_WORD_W,
   parameter int unsigned OPERAND_W   = MONT_OPERAND_W,
   parameter int unsigned TIMEOUT_CYC = 1024
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 s_valid,
   output logic                 s_ready,
   input  logic [WORD_W-1:0]    s_data,
   output logic                 m_valid,
   input  logic                 m_ready,
   output logic [WORD_W-1:0]    m_data,
   output logic                 busy,
   output logic                 err,
   output logic                 mm_start,
   output logic [OPERAND_W-1:0] mm_a,
   output logic [OPERAND_W-1:0] mm_b,
   output logic [OPERAND_W-1:0] mm_m,
   input  logic [OPERAND_W-1:0] mm_result,
   input  logic                 mm_done
);

   localparam int unsigned NWORDS = OPERAND_W / WORD_W;
   localparam int unsigned IDX_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
   localparam int unsigned TMO_W  = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

   mont_state_t          r_state;
   mont_state_t          w_state_nxt;
   mont_sel_t            r_sel;
   logic [IDX_W-1:0]     r_idx;
   logic [TMO_W-1:0]     r_tmo;
   logic                 r_err;

   logic                 w_in_hs;
   logic                 w_out_hs;
   logic                 w_we_a;
   logic                 w_we_b;
   logic                 w_we_m;
   logic                 w_res_ld;
   logic                 w_tmo_hit;

   logic [WORD_W-1:0]    w_a_word;
   logic [WORD_W-1:0]    w_b_word;
   logic [WORD_W-1:0]    w_m_word;
   logic [OPERAND_W-1:0] w_res_value;
   logic [3*WORD_W+OPERAND_W-1:0] w_unused_rd;

   // Handshake strobes and status outputs, all decoded from registered state.
   assign s_ready  = (r_state == ST_LOAD) && resetn;
   assign m_valid  = (r_state == ST_UNLOAD);
   assign mm_start = (r_state == ST_START);
   assign busy     = (r_state != ST_LOAD);
   assign err      = r_err;
   assign w_in_hs  = s_valid && s_ready;
   assign w_out_hs = m_valid && m_ready;

   // Read ports of the operand packers and full value of the result packer
   // are not needed here.
   assign w_unused_rd = {w_a_word, w_b_word, w_m_word, w_res_value};

   // Next-state decode and per-cycle strobes.
   always_comb begin
      w_state_nxt = r_state;
      w_we_a      = 1'b0;
      w_we_b      = 1'b0;
      w_we_m      = 1'b0;
      w_res_ld    = 1'b0;
      w_tmo_hit   = 1'b0;
      case (r_state)
         ST_LOAD: begin
            if (w_in_hs) begin
               w_we_a = (r_sel == SEL_A);
               w_we_b = (r_sel == SEL_B);
               w_we_m = (r_sel == SEL_M);
               if ((r_sel == SEL_M) && (r_idx == LAST_IDX)) begin
                  w_state_nxt = ST_START;
               end
            end
         end
         ST_START: begin
            w_state_nxt = ST_WAIT;
         end
         ST_WAIT: begin
            if (mm_done) begin
               w_res_ld    = 1'b1;
               w_state_nxt = ST_UNLOAD;
            end else if (r_tmo == TMO_LAST) begin
               w_tmo_hit   = 1'b1;
               w_state_nxt = ST_LOAD;
            end
         end
         ST_UNLOAD: begin
            if (w_out_hs && (r_idx == LAST_IDX)) begin
               w_state_nxt = ST_LOAD;
            end
         end
         default: begin
            w_state_nxt = ST_LOAD;
         end
      endcase
   end

   // State, word/operand counters, timeout counter and sticky error flag.
   // The timeout counter already runs in START so that the abort lands
   // TIMEOUT_CYC cycles after the start pulse.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_state <= ST_LOAD;
         r_sel   <= SEL_A;
         r_idx   <= '0;
         r_tmo   <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         case (r_state)
            ST_LOAD: begin
               r_tmo <= '0;
               if (w_in_hs) begin
                  if ((r_sel == SEL_A) && (r_idx == '0)) begin
                     r_err <= 1'b0;
                  end
                  if (r_idx == LAST_IDX) begin
                     r_idx <= '0;
                     r_sel <= mont_next_sel(r_sel);
                  end else begin
                     r_idx <= r_idx + 1'b1;
                  end
               end
            end
            ST_START: begin
               r_tmo <= r_tmo + 1'b1;
            end
            ST_WAIT: begin
               r_tmo <= r_tmo + 1'b1;
               if (w_tmo_hit) begin
                  r_err <= 1'b1;
               end
            end
            ST_UNLOAD: begin
               if (w_out_hs) begin
                  r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
               end
            end
            default: begin
               r_idx <= '0;
            end
         endcase
      end
   end

   mont_word_packer #(
      .WORD_W    (WORD_W),
      .OPERAND_W (OPERAND_W)
   ) u_pack_a (
      .clk       (clk),
      .resetn    (resetn),
      .i_we      (w_we_a),
      .i_wr_idx  (r_idx),
      .i_wr_data (s_data),
      .i_ld      (1'b0),
      .i_ld_data ('0),
      .i_rd_idx  ('0),
      .o_rd_data (w_a_word),
      .o_value   (mm_a)
   );

   mont_word_packer #(
      .WORD_W    (WORD_W),
      .OPERAND_W (OPERAND_W)
   ) u_pack_b (
      .clk       (clk),
      .resetn    (resetn),
      .i_we      (w_we_b),
      .i_wr_idx  (r_idx),
      .i_wr_data (s_data),
      .i_ld      (1'b0),
      .i_ld_data ('0),
      .i_rd_idx  ('0),
      .o_rd_data (w_b_word),
      .o_value   (mm_b)
   );

   mont_word_packer #(
      .WORD_W    (WORD_W),
      .OPERAND_W (OPERAND_W)
   ) u_pack_m (
      .clk       (clk),
      .resetn    (resetn),
      .i_we      (w_we_m),
      .i_wr_idx  (r_idx),
      .i_wr_data (s_data),
      .i_ld      (1'b0),
      .i_ld_data ('0),
      .i_rd_idx  ('0),
      .o_rd_data (w_m_word),
      .o_value   (mm_m)
   );

   mont_word_packer #(
      .WORD_W    (WORD_W),
      .OPERAND_W (OPERAND_W)
   ) u_pack_res (
      .clk       (clk),
      .resetn    (resetn),
      .i_we      (1'b0),
      .i_wr_idx  ('0),
      .i_wr_data ('0),
      .i_ld      (w_res_ld),
      .i_ld_data (mm_result),
      .i_rd_idx  (r_idx),
      .o_rd_data (m_data),
      .o_value   (w_res_value)
   );

endmodule

// File: tb/tb_mont_word_bridge.sv
// Directed bench for mont_word_bridge; the multiplier is stubbed by driving
// mm_done/mm_result from the stimulus process.
module tb_mont_word_bridge;

   logic         clk;
   logic         resetn;
   logic         s_valid;
   logic         s_ready;
   logic [31:0]  s_data;
   logic         m_valid;
   logic         m_ready;
   logic [31:0]  m_data;
   logic         busy;
   logic         err;
   logic         mm_start;
   logic [511:0] mm_a;
   logic [511:0] mm_b;
   logic [511:0] mm_m;
   logic [511:0] mm_result;
   logic         mm_done;

   int n_chk = 0;
   int n_err = 0;
   int n_start = 0;

   mont_word_bridge #(
      .WORD_W      (32),
      .OPERAND_W   (512),
      .TIMEOUT_CYC (1024)
   ) dut (
      .clk       (clk),
      .resetn    (resetn),
      .s_valid   (s_valid),
      .s_ready   (s_ready),
      .s_data    (s_data),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .m_data    (m_data),
      .busy      (busy),
      .err       (err),
      .mm_start  (mm_start),
      .mm_a      (mm_a),
      .mm_b      (mm_b),
      .mm_m      (mm_m),
      .mm_result (mm_result),
      .mm_done   (mm_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count start pulses seen on active edges.
   always @(posedge clk) begin
      if (resetn && mm_start) n_start++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Expected operand value when the stream carried base, base+1, ...
   function automatic logic [511:0] mk_op(input logic [31:0] base, input int sel);
      logic [511:0] v;
      v = '0;
      for (int i = 0; i < 16; i++) v[i*32 +: 32] = base + 32'(sel*16 + i);
      return v;
   endfunction

   // Push n consecutive words starting at base; counts cycles where the
   // bridge was not ready.
   task automatic load_words(input logic [31:0] base, input int n, output int nrdy);
      nrdy = 0;
      for (int i = 0; i < n; i++) begin
         s_valid = 1'b1;
         s_data  = base + 32'(i);
         if (!s_ready) nrdy++;
         tick();
      end
      s_valid = 1'b0;
   endtask

   task automatic pulse_done(input logic [511:0] res);
      mm_result = res;
      mm_done   = 1'b1;
      tick();
      mm_done   = 1'b0;
      mm_result = {16{32'h5A5A5A5A}};
   endtask

   // Drain result words with m_ready following pat[c%4]; bounded by 200 cycles.
   task automatic unload(input logic [3:0] pat, output logic [511:0] got,
                         output int nhs, output int nunst, output int nbusy_rdy);
      logic [31:0] prev;
      logic        stalled;
      got = '0; nhs = 0; nunst = 0; nbusy_rdy = 0; stalled = 1'b0; prev = '0;
      for (int c = 0; c < 200; c++) begin
         if (!m_valid) break;
         m_ready = pat[c % 4];
         if (s_ready) nbusy_rdy++;
         if (stalled && (m_data !== prev)) nunst++;
         if (m_ready) begin
            if (nhs < 16) got[nhs*32 +: 32] = m_data;
            nhs++;
            stalled = 1'b0;
         end else begin
            prev    = m_data;
            stalled = 1'b1;
         end
         tick();
      end
      m_ready = 1'b0;
      s_valid = 1'b0;
   endtask

   logic [511:0] r1, r2, r3, got;
   int nrdy, nhs, nunst, nbr, cnt_rdy, cnt_mv, t;

   initial begin
      r1 = 512'h1_FFFFFFFF;
      r2 = '0;
      r3 = '0;
      for (int i = 0; i < 16; i++) begin
         r2[i*32 +: 32] = 32'hA500_0000 | 32'(i * 17);
         r3[i*32 +: 32] = 32'hC0DE_0000 + 32'(i);
      end
      resetn = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
      mm_done = 1'b0; mm_result = '0;
      repeat (2) tick();

      // Reset state
      chk("rst_s_ready", s_ready, 0);
      chk("rst_m_valid", m_valid, 0);
      chk("rst_mm_start", mm_start, 0);
      chk("rst_err", err, 0);
      chk("rst_busy", busy, 0);
      chk("rst_mm_a", mm_a, 0);
      resetn = 1'b1;
      tick();
      chk("rel_s_ready", s_ready, 1);

      // Run 1: load 0..2F, done 300 cycles after start, full-rate drain
      load_words(32'h0, 48, nrdy);
      chk("l1_not_ready", nrdy, 0);
      chk("l1_start", mm_start, 1);
      chk("l1_s_ready_start", s_ready, 0);
      chk("l1_busy", busy, 1);
      chk("l1_a_w0", mm_a[31:0], 32'h0);
      chk("l1_a_w15", mm_a[511:480], 32'hF);
      chk("l1_b_w0", mm_b[31:0], 32'h10);
      chk("l1_m_w15", mm_m[511:480], 32'h2F);
      chk("l1_a", mm_a, mk_op(32'h0, 0));
      chk("l1_b", mm_b, mk_op(32'h0, 1));
      chk("l1_m", mm_m, mk_op(32'h0, 2));
      s_valid = 1'b1;
      s_data  = 32'hDEADBEEF;
      tick();
      chk("l1_start_once", mm_start, 0);
      cnt_rdy = 0; cnt_mv = 0;
      for (int i = 1; i < 300; i++) begin
         if (s_ready) cnt_rdy++;
         if (m_valid) cnt_mv++;
         tick();
      end
      chk("w1_s_ready", cnt_rdy, 0);
      chk("w1_m_valid", cnt_mv, 0);
      pulse_done(r1);
      chk("d1_m_valid", m_valid, 1);
      unload(4'b1111, got, nhs, nunst, nbr);
      chk("u1_word0", got[31:0], 32'hFFFFFFFF);
      chk("u1_word1", got[63:32], 32'h1);
      chk("u1_result", got, r1);
      chk("u1_nhs", nhs, 16);
      chk("u1_s_ready_busy", nbr, 0);
      chk("u1_m_valid_drop", m_valid, 0);
      chk("u1_s_ready_after", s_ready, 1);
      chk("u1_a_hold", mm_a, mk_op(32'h0, 0));
      chk("u1_m_hold", mm_m, mk_op(32'h0, 2));
      chk("u1_err", err, 0);

      // mm_done while idle is ignored
      pulse_done(r2);
      chk("idle_done_mv", m_valid, 0);
      chk("idle_done_busy", busy, 0);

      // Run 2: backpressure 1,0,0,1
      load_words(32'h100, 48, nrdy);
      chk("l2_start", mm_start, 1);
      chk("l2_b", mm_b, mk_op(32'h100, 1));
      repeat (5) tick();
      pulse_done(r2);
      unload(4'b1001, got, nhs, nunst, nbr);
      chk("u2_result", got, r2);
      chk("u2_nhs", nhs, 16);
      chk("u2_stable", nunst, 0);
      chk("u2_m_valid_drop", m_valid, 0);

      // Run 3: timeout
      load_words(32'h200, 48, nrdy);
      chk("l3_start", mm_start, 1);
      t = 0; cnt_mv = 0;
      while (t < 2000) begin
         tick();
         t++;
         if (m_valid) cnt_mv++;
         if (err) break;
      end
      chk("t3_cycles", t, 1024);
      chk("t3_busy", busy, 0);
      chk("t3_no_m_valid", cnt_mv, 0);
      repeat (3) tick();
      chk("t3_err_sticky", err, 1);
      load_words(32'h400, 1, nrdy);
      chk("t3_err_clear", err, 0);

      // Reset mid-load after 20 words
      load_words(32'h401, 19, nrdy);
      resetn = 1'b0;
      tick();
      chk("mr_s_ready", s_ready, 0);
      chk("mr_busy", busy, 0);
      chk("mr_mm_a", mm_a, 0);
      chk("mr_mm_b", mm_b, 0);
      chk("mr_mm_m", mm_m, 0);
      resetn = 1'b1;
      tick();

      // Run 4: fresh load; done lands on the last timeout cycle and must win
      load_words(32'h300, 48, nrdy);
      chk("l4_start", mm_start, 1);
      chk("l4_a", mm_a, mk_op(32'h300, 0));
      chk("l4_b", mm_b, mk_op(32'h300, 1));
      chk("l4_m", mm_m, mk_op(32'h300, 2));
      repeat (1023) tick();
      chk("l4_pre_err", err, 0);
      pulse_done(r3);
      chk("d4_m_valid", m_valid, 1);
      chk("d4_err", err, 0);
      unload(4'b1111, got, nhs, nunst, nbr);
      chk("u4_result", got, r3);
      chk("u4_nhs", nhs, 16);
      chk("n_start_total", n_start, 4);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
